design_select_ctrl: RTL

- Per-chip controller that sequences the shared multi-project user area: it decides which design is active, how that design is reset, and when it is frozen.
- Captures the 6-bit design number from the pins on a sync strobe. Drives a one-hot design enable and the output-mux select.
- Runs a fixed-length reset sequence on every design switch and on every external reset.
- Implements the hold (freeze) input. Sits between the raw io_in control pins and the per-design enable/reset/mux fabric.

---
 rtl/design_select_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/design_select_ctrl.sv
// Multi-project user-area select controller: captures the design number on a pin strobe,
// sequences the per-design reset and enable, and freezes the active design on hold.
module design_select_ctrl #(
    parameter int NUM_DESIGNS = 44,
    parameter int SEL_W       = 6,
    parameter int RST_CYCLES  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SEL_W-1:0]       des_sel_in,
    input  logic                   sync_in,
    input  logic                   hold_in,
    input  logic                   ext_reset_in,
    output logic [NUM_DESIGNS-1:0] design_en,
    output logic                   design_reset,
    output logic [SEL_W-1:0]       mux_sel,
    output logic                   active_valid,
    output logic                   busy
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [SEL_W:0] NUM_LIMIT = (SEL_W + 1)'(NUM_DESIGNS);

    // IDLE: no design | SWITCH: design held in reset | RUN: active | HOLD: frozen
    typedef enum logic [1:0] {IDLE, SWITCH, RUN, HOLD} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_sr, hold_sr, ext_sr;
    logic [SEL_W-1:0]       des_sr [SYNC_STAGES];
    logic                   sync_d;
    logic                   sync_s, hold_s, ext_s, sync_edge;
    logic [SEL_W-1:0]       des_s;

    logic [SEL_W-1:0]       sel_reg, sel_next;
    logic [CNT_W-1:0]       counter, cnt_next;
    logic                   valid_next, reset_next, busy_next;
    logic [NUM_DESIGNS-1:0] en_next;

    assign sync_s    = sync_sr[SYNC_STAGES-1];
    assign hold_s    = hold_sr[SYNC_STAGES-1];
    assign ext_s     = ext_sr[SYNC_STAGES-1];
    assign des_s     = des_sr[SYNC_STAGES-1];
    assign sync_edge = sync_s & ~sync_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_sr <= '0;
            hold_sr <= '0;
            ext_sr  <= '0;
            sync_d  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) des_sr[i] <= '0;
        end else begin
            sync_sr   <= {sync_sr[SYNC_STAGES-2:0], sync_in};
            hold_sr   <= {hold_sr[SYNC_STAGES-2:0], hold_in};
            ext_sr    <= {ext_sr[SYNC_STAGES-2:0], ext_reset_in};
            sync_d    <= sync_s;
            des_sr[0] <= des_sel_in;
            for (int i = 1; i < SYNC_STAGES; i++) des_sr[i] <= des_sr[i-1];
        end
    end

    always_comb begin
        state_next = state;
        sel_next   = sel_reg;
        cnt_next   = counter;
        valid_next = active_valid;
        if (sync_edge) begin
            sel_next   = des_s;
            cnt_next   = '0;
            valid_next = ({1'b0, des_s} < NUM_LIMIT);
            state_next = valid_next ? SWITCH : IDLE;
        end else begin
            case (state)
                SWITCH: begin
                    if (ext_s) begin
                        cnt_next = '0;
                    end else if (counter == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        cnt_next = counter + 1'b1;
                    end
                end
                RUN: begin
                    if (ext_s) begin
                        cnt_next   = '0;
                        state_next = SWITCH;
                    end else if (hold_s) begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (ext_s) begin
                        cnt_next   = '0;
                        state_next = SWITCH;
                    end else if (!hold_s) begin
                        state_next = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so that every output is a flop.
    always_comb begin
        en_next    = '0;
        reset_next = 1'b1;
        busy_next  = 1'b0;
        case (state_next)
            SWITCH: begin
                en_next   = NUM_DESIGNS'(1) << sel_next;
                busy_next = 1'b1;
            end
            RUN: begin
                en_next    = NUM_DESIGNS'(1) << sel_next;
                reset_next = 1'b0;
            end
            HOLD:    reset_next = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            sel_reg      <= '0;
            counter      <= '0;
            design_en    <= '0;
            design_reset <= 1'b1;
            mux_sel      <= '0;
            active_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            sel_reg      <= sel_next;
            counter      <= cnt_next;
            design_en    <= en_next;
            design_reset <= reset_next;
            mux_sel      <= sel_next;
            active_valid <= valid_next;
            busy         <= busy_next;
        end
    end

endmodule
